// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two requester handshakes (A and B) and the
//               single-port RAM pins shared through ram_arbiter.
//               slave  modport : arbiter view (takes requests, drives RAM)
//               master modport : requester/RAM-side view (drives requests,
//                                returns RAM read data)
// Signals     : a_req/a_we/a_addr/a_wdata -> arbiter, a_gnt/a_rvalid/a_rdata <-
//               b_req/b_we/b_addr/b_wdata -> arbiter, b_gnt/b_rvalid/b_rdata <-
//               ram_address/ram_load/ram_in <- arbiter, ram_out -> arbiter
// Revision    : 1.0  initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_load;
    logic [DATA_WIDTH-1:0] ram_in;
    logic [DATA_WIDTH-1:0] ram_out;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_address, ram_load, ram_in,
        input  ram_out
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_address, ram_load, ram_in,
        output ram_out
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port synchronous RAM (1-cycle read latency)
//               between requester A (CPU data port) and requester B
//               (secondary master). One access is granted per cycle; read
//               data returns to the issuing requester two cycles after grant.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - ram_arbiter_if.slave: A/B request handshakes and the
//                       RAM address/load/in/out pins
// Options     : RAM_ARB_ROUND_ROBIN_EN - when defined, contention is resolved
//               round-robin and STARVE_LIMIT is ignored; otherwise A has fixed
//               priority with a B starvation guard.
// Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_arbiter_if.slave   bus
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    logic                  w_both;
    logic                  w_b_wins;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Issue stage: a read is in the RAM's output register this cycle
    logic                  s1_vld_q, s1_vld_d;
    req_id_t               s1_id_q,  s1_id_d;

    // Return stage
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_q,  b_rdata_q;

    assign w_both = bus.a_req & bus.b_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Most recent winner; resets to B so A wins the first contention.
    req_id_t last_gnt_q, last_gnt_d;

    assign w_b_wins = w_both & (last_gnt_q == REQ_A);

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (w_gnt_a)      last_gnt_d = REQ_A;
        else if (w_gnt_b) last_gnt_d = REQ_B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_gnt_q <= REQ_B;
        else        last_gnt_q <= last_gnt_d;
    end
`else
    localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] c_LIMIT = WAIT_W'(STARVE_LIMIT);

    // Cycles B has been kept waiting while requesting, saturating at the limit.
    logic [WAIT_W-1:0] b_wait_q, b_wait_d;

    assign w_b_wins = w_both & (STARVE_LIMIT != 0) & (b_wait_q == c_LIMIT);

    always_comb begin
        b_wait_d = b_wait_q;
        if (!bus.b_req || w_gnt_b)  b_wait_d = '0;
        else if (b_wait_q != c_LIMIT) b_wait_d = b_wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_wait_q <= '0;
        else        b_wait_q <= b_wait_d;
    end
`endif

    // A wins unless the contention rule hands this cycle to B.
    assign w_gnt_a = bus.a_req & ~w_b_wins;
    assign w_gnt_b = bus.b_req & ~w_gnt_a;

    // Idle cycles park the RAM on A's address/data with load low.
    assign w_addr  = w_gnt_b ? bus.b_addr  : bus.a_addr;
    assign w_wdata = w_gnt_b ? bus.b_wdata : bus.a_wdata;

    assign bus.a_gnt       = w_gnt_a;
    assign bus.b_gnt       = w_gnt_b;
    assign bus.ram_address = w_addr;
    assign bus.ram_in      = w_wdata;
    assign bus.ram_load    = (w_gnt_a & bus.a_we) | (w_gnt_b & bus.b_we);

    always_comb begin
        s1_vld_d = (w_gnt_a & ~bus.a_we) | (w_gnt_b & ~bus.b_we);
        s1_id_d  = w_gnt_b ? REQ_B : REQ_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_id_q    <= REQ_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_id_q    <= s1_id_d;
            a_rvalid_q <= s1_vld_q & (s1_id_q == REQ_A);
            b_rvalid_q <= s1_vld_q & (s1_id_q == REQ_B);
            // ram_out now holds the word addressed in the issue cycle.
            if (s1_vld_q && s1_id_q == REQ_A) a_rdata_q <= bus.ram_out;
            if (s1_vld_q && s1_id_q == REQ_B) b_rdata_q <= bus.ram_out;
        end
    end

    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;

endmodule
`default_nettype wire
